// File: rtl/poly_eval_arbiter_if.sv
// Request/ack and result bundle between two requesters and poly_eval_arbiter.
// master = requester side, slave = evaluator side.
interface poly_eval_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0;
    logic [4*WIDTH-1:0]   op0;
    logic                 ack0;
    logic                 req1;
    logic [4*WIDTH-1:0]   op1;
    logic                 ack1;
    logic                 busy;
    logic [WIDTH-1:0]     result;
    logic                 result_valid;
    logic                 result_id;

    modport master (
        output req0, op0, req1, op1,
        input  ack0, ack1, busy, result, result_valid, result_id
    );

    modport slave (
        input  req0, op0, req1, op1,
        output ack0, ack1, busy, result, result_valid, result_id
    );
endinterface

// File: rtl/poly_eval_arbiter.sv
// Round-robin front end for one shared add/multiply ALU that evaluates
// A*x*x + B*x + C in Horner form over four cycles, mod 2^WIDTH.
module poly_eval_arbiter #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    poly_eval_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CYC0,
        CYC1,
        CYC2,
        CYC3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   result;
    logic               last_id;
    logic               id;
    logic               result_id;
    logic               result_valid;
    logic               ack0;
    logic               ack1;

    logic               grant_valid;
    logic               grant_id;
    logic [4*WIDTH-1:0] grant_op;

    logic [WIDTH-1:0]   alu_x;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_mul;
    logic [WIDTH-1:0]   alu_prod;
    logic [WIDTH-1:0]   alu_out;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        grant_id    = (bus.req0 && bus.req1) ? ~last_id : bus.req1;
        grant_op    = grant_id ? bus.op1 : bus.op0;
    end

    // The single ALU: operand selection per Horner step.
    always_comb begin
        alu_x   = acc;
        alu_y   = b;
        alu_mul = 1'b0;
        unique case (state)
            CYC0: begin
                alu_x   = a;
                alu_y   = x;
                alu_mul = 1'b1;
            end
            CYC1: begin
                alu_x = acc;
                alu_y = b;
            end
            CYC2: begin
                alu_x   = acc;
                alu_y   = x;
                alu_mul = 1'b1;
            end
            CYC3: begin
                alu_x = acc;
                alu_y = c;
            end
            default: begin
                alu_x = acc;
                alu_y = b;
            end
        endcase
        alu_prod = alu_x * alu_y;
        alu_out  = alu_mul ? alu_prod : alu_x + alu_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            c            <= '0;
            x            <= '0;
            acc          <= '0;
            result       <= '0;
            result_id    <= 1'b0;
            result_valid <= 1'b0;
            id           <= 1'b0;
            last_id      <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
        end else begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        a       <= grant_op[4*WIDTH-1 -: WIDTH];
                        b       <= grant_op[3*WIDTH-1 -: WIDTH];
                        c       <= grant_op[2*WIDTH-1 -: WIDTH];
                        x       <= grant_op[WIDTH-1 -: WIDTH];
                        last_id <= grant_id;
                        id      <= grant_id;
                        ack0    <= ~grant_id;
                        ack1    <= grant_id;
                        state   <= CYC0;
                    end
                end
                CYC0: begin
                    acc   <= alu_out;
                    state <= CYC1;
                end
                CYC1: begin
                    acc   <= alu_out;
                    state <= CYC2;
                end
                CYC2: begin
                    acc   <= alu_out;
                    state <= CYC3;
                end
                CYC3: begin
                    result       <= alu_out;
                    result_id    <= id;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0         = ack0;
    assign bus.ack1         = ack1;
    assign bus.busy         = (state != IDLE);
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.result_id    = result_id;
endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Self-checking bench for poly_eval_arbiter: directed scenarios plus random
// jobs scored against a direct A*x^2+B*x+C reference.
module tb_poly_eval_arbiter;
    logic clk = 1'b0;
    logic reset;

    poly_eval_arbiter_if #(.WIDTH(8)) bus ();

    poly_eval_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] rq_res[$];
    logic       rq_id[$];
    bit         both_ack = 1'b0;

    always @(negedge clk) begin
        if (bus.result_valid) begin
            rq_res.push_back(bus.result);
            rq_id.push_back(bus.result_id);
        end
        if (bus.ack0 && bus.ack1) both_ack = 1'b1;
    end

    function automatic logic [7:0] poly(input logic [31:0] op);
        int unsigned a, b, c, x;
        a = op[31:24];
        b = op[23:16];
        c = op[15:8];
        x = op[7:0];
        return 8'((a * x * x + b * x + c) % 256);
    endfunction

    function automatic logic [31:0] mk(input int a, input int b, input int c, input int x);
        return {a[7:0], b[7:0], c[7:0], x[7:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        rq_res.delete();
        rq_id.delete();
    endtask

    // Drives one job from a single requester; latencies are -1 on timeout.
    task automatic do_job(input bit who, input logic [31:0] op,
                          output int ack_lat, output int res_lat,
                          output logic [7:0] res, output logic rid);
        ack_lat = -1;
        res_lat = -1;
        res = 'x;
        rid = 1'bx;
        if (who) begin
            bus.op1 = op;
            bus.req1 = 1'b1;
        end else begin
            bus.op0 = op;
            bus.req0 = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (who ? bus.ack1 : bus.ack0) begin
                ack_lat = i;
                break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (ack_lat > 0) begin
            for (int i = 1; i <= 20; i++) begin
                tick;
                if (bus.result_valid) begin
                    res_lat = i;
                    res = bus.result;
                    rid = bus.result_id;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        apply_reset;
        total_cnt++;
        if ({bus.ack0, bus.ack1, bus.busy, bus.result_valid, bus.result_id} !== 5'b0)
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.ack0, bus.ack1, bus.busy, bus.result_valid, bus.result_id});
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 8'h00) $display("FAIL reset_result got=%h want=00", bus.result);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        logic [7:0] res;
        logic rid;
        int al, rl;
        do_job(1'b0, mk(1, 2, 3, 4), al, rl, res, rid);
        total_cnt++;
        if (al !== 1) $display("FAIL basic_ack_lat got=%0d want=1", al);
        else pass_cnt++;
        total_cnt++;
        if (rl !== 4) $display("FAIL basic_res_lat got=%0d want=4", rl);
        else pass_cnt++;
        total_cnt++;
        if (res !== 8'h1B || rid !== 1'b0)
            $display("FAIL basic_result got=%h/%b want=1b/0", res, rid);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (bus.result_valid !== 1'b0 || bus.result !== 8'h1B || bus.busy !== 1'b0)
            $display("FAIL basic_hold got rv=%b res=%h busy=%b want 0/1b/0",
                     bus.result_valid, bus.result, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        logic [7:0] res;
        logic rid;
        int al, rl;
        do_job(1'b1, mk(8'h10, 0, 1, 8'h10), al, rl, res, rid);
        total_cnt++;
        if (res !== 8'h01 || rid !== 1'b1 || rl !== 4)
            $display("FAIL wrap_a got=%h/%b lat=%0d want=01/1 lat=4", res, rid, rl);
        else pass_cnt++;
        do_job(1'b1, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), al, rl, res, rid);
        total_cnt++;
        if (res !== 8'hFF || rid !== 1'b1)
            $display("FAIL wrap_ff got=%h/%b want=ff/1", res, rid);
        else pass_cnt++;
    endtask

    task automatic test_tie;
        int t0, t1;
        logic [31:0] o0, o1;
        apply_reset;
        o0 = $urandom();
        o1 = $urandom();
        t0 = -1;
        t1 = -1;
        bus.op0 = o0;
        bus.op1 = o1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bus.ack0 && t0 < 0) begin
                t0 = i;
                bus.req0 = 1'b0;
            end
            if (bus.ack1 && t1 < 0) begin
                t1 = i;
                bus.req1 = 1'b0;
            end
            if (t0 > 0 && t1 > 0 && rq_res.size() >= 2) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        total_cnt++;
        if (t0 !== 1) $display("FAIL tie_ack0 got=%0d want=1", t0);
        else pass_cnt++;
        total_cnt++;
        if (t1 - t0 !== 5) $display("FAIL tie_gap got=%0d want=5", t1 - t0);
        else pass_cnt++;
        total_cnt++;
        if (rq_res.size() !== 2) $display("FAIL tie_count got=%0d want=2", rq_res.size());
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] gr, er;
            logic gi;
            gr = (rq_res.size() > k) ? rq_res[k] : 8'hxx;
            gi = (rq_id.size() > k) ? rq_id[k] : 1'bx;
            er = (k == 0) ? poly(o0) : poly(o1);
            total_cnt++;
            if (gr !== er || gi !== k[0])
                $display("FAIL tie_res%0d got=%h/%b want=%h/%b", k, gr, gi, er, k[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_res[$];
        logic       order[$];
        int n;
        apply_reset;
        n = 0;
        bus.op0 = $urandom();
        bus.op1 = $urandom();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (bus.ack0) begin
                order.push_back(1'b0);
                exp_res.push_back(poly(bus.op0));
                bus.op0 = $urandom();
                n++;
            end
            if (bus.ack1) begin
                order.push_back(1'b1);
                exp_res.push_back(poly(bus.op1));
                bus.op1 = $urandom();
                n++;
            end
            if (n >= 6) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            if (n >= 6 && rq_res.size() >= 6) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        total_cnt++;
        if (rq_res.size() !== 6 || order.size() !== 6)
            $display("FAIL fair_count got=%0d/%0d want=6/6", order.size(), rq_res.size());
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            logic go, gi;
            logic [7:0] gr, er;
            go = (order.size() > k) ? order[k] : 1'bx;
            gi = (rq_id.size() > k) ? rq_id[k] : 1'bx;
            gr = (rq_res.size() > k) ? rq_res[k] : 8'hxx;
            er = (exp_res.size() > k) ? exp_res[k] : 8'hxx;
            total_cnt++;
            if (go !== k[0]) $display("FAIL fair_order%0d got=%b want=%b", k, go, k[0]);
            else pass_cnt++;
            total_cnt++;
            if (gr !== er || gi !== k[0])
                $display("FAIL fair_res%0d got=%h/%b want=%h/%b", k, gr, gi, er, k[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int acks[$];
        apply_reset;
        bus.op0 = $urandom();
        bus.req0 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (bus.ack0) acks.push_back(i);
            if (acks.size() >= 3) break;
        end
        bus.req0 = 1'b0;
        total_cnt++;
        if (acks.size() !== 3 || acks[1] - acks[0] !== 5 || acks[2] - acks[1] !== 5)
            $display("FAIL b2b_spacing got n=%0d want 3 acks 5 apart", acks.size());
        else pass_cnt++;
        repeat (6) tick;
    endtask

    task automatic test_busy;
        logic [31:0] o0, o1;
        int rv_t, a1_t;
        logic busy_at_rv;
        logic [7:0] r0;
        logic [7:0] r1;
        logic id1;
        apply_reset;
        o0 = $urandom();
        o1 = $urandom();
        rv_t = -1;
        a1_t = -1;
        busy_at_rv = 1'bx;
        r0 = 'x;
        r1 = 'x;
        id1 = 1'bx;
        bus.op0 = o0;
        bus.req0 = 1'b1;
        tick;
        bus.req0 = 1'b0;
        tick;
        bus.op1 = o1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (bus.ack1 && a1_t < 0) begin
                a1_t = i;
                bus.req1 = 1'b0;
            end
            if (bus.result_valid && rv_t < 0) begin
                rv_t = i;
                busy_at_rv = bus.busy;
                r0 = bus.result;
            end
            if (a1_t > 0) break;
        end
        bus.req1 = 1'b0;
        total_cnt++;
        if (rv_t !== 3 || a1_t !== rv_t + 1)
            $display("FAIL busy_ack1 got rv=%0d ack1=%0d want rv=3 ack1=4", rv_t, a1_t);
        else pass_cnt++;
        total_cnt++;
        if (busy_at_rv !== 1'b0) $display("FAIL busy_gap got=%b want=0", busy_at_rv);
        else pass_cnt++;
        total_cnt++;
        if (r0 !== poly(o0)) $display("FAIL busy_res0 got=%h want=%h", r0, poly(o0));
        else pass_cnt++;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (bus.result_valid) begin
                r1 = bus.result;
                id1 = bus.result_id;
                break;
            end
        end
        total_cnt++;
        if (r1 !== poly(o1) || id1 !== 1'b1)
            $display("FAIL busy_res1 got=%h/%b want=%h/1", r1, id1, poly(o1));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_job;
        int t0, t1;
        apply_reset;
        bus.op0 = mk(1, 2, 3, 4);
        bus.req0 = 1'b1;
        tick;
        bus.req0 = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        total_cnt++;
        if ({bus.ack0, bus.ack1, bus.busy, bus.result_valid, bus.result_id, bus.result} !== 13'b0)
            $display("FAIL midreset_outs got=%b want=0",
                     {bus.ack0, bus.ack1, bus.busy, bus.result_valid, bus.result_id, bus.result});
        else pass_cnt++;
        reset = 1'b0;
        repeat (4) tick;
        total_cnt++;
        if (rq_res.size() !== 0) $display("FAIL midreset_dropped got=%0d want=0", rq_res.size());
        else pass_cnt++;
        t0 = -1;
        t1 = -1;
        bus.op0 = $urandom();
        bus.op1 = $urandom();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (bus.ack0 && t0 < 0) begin
                t0 = i;
                bus.req0 = 1'b0;
            end
            if (bus.ack1 && t1 < 0) begin
                t1 = i;
                bus.req1 = 1'b0;
            end
            if (t0 > 0 && t1 > 0) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        total_cnt++;
        if (t0 !== 1 || t1 !== 6)
            $display("FAIL midreset_tie got ack0=%0d ack1=%0d want 1/6", t0, t1);
        else pass_cnt++;
        repeat (6) tick;
    endtask

    task automatic test_random;
        logic [31:0] op;
        logic [7:0] res;
        logic rid;
        bit who;
        int al, rl;
        for (int k = 0; k < 16; k++) begin
            op = $urandom();
            who = 1'($urandom_range(0, 1));
            do_job(who, op, al, rl, res, rid);
            total_cnt++;
            if (al !== 1 || rl !== 4)
                $display("FAIL rand%0d_lat got=%0d/%0d want=1/4", k, al, rl);
            else pass_cnt++;
            total_cnt++;
            if (res !== poly(op) || rid !== who)
                $display("FAIL rand%0d_res got=%h/%b want=%h/%b", k, res, rid, poly(op), who);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.op0 = '0;
        bus.op1 = '0;
        test_reset;
        test_basic;
        test_wrap;
        test_tie;
        test_fairness;
        test_back_to_back;
        test_busy;
        test_reset_mid_job;
        test_random;
        total_cnt++;
        if (both_ack !== 1'b0) $display("FAIL ack_overlap got=%b want=0", both_ack);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
